// File: rtl/dac_pkg.sv
// Shared definitions for the spi2dac sample scheduler: FSM encoding and
// sample-rate divider constants for a 50 MHz system clock.
package dac_pkg;

  localparam int DW_DEFAULT      = 10;
  localparam int TIMEOUT_DEFAULT = 255;

  localparam int DIV_10K  = 5000;
  localparam int DIV_20K  = 2500;
  localparam int DIV_44K1 = 1134;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_FALL = 2'd2,
    WAIT_RISE = 2'd3
  } state_t;

endpackage

// File: rtl/rate_tick.sv
// Free-running slot divider: one-cycle tick every DIV sysclk cycles, first
// tick DIV-1 cycles after reset release.
module rate_tick #(
  parameter int DIV = 5000
) (
  input  logic sysclk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == '0);

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n)
      cnt <= RELOAD;
    else if (tick)
      cnt <= RELOAD;
    else
      cnt <= cnt - CW'(1);
  end

endmodule

// File: rtl/dac_sample_scheduler.sv
// Round-robin two-source sample scheduler for spi2dac: arbitrates once per
// slot tick, issues a one-cycle load, then follows the dac_cs frame.
module dac_sample_scheduler
  import dac_pkg::*;
#(
  parameter int DW      = DW_DEFAULT,
  parameter int DIV     = DIV_10K,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic          sysclk,
  input  logic          rst_n,
  input  logic [1:0]    req,
  input  logic [DW-1:0] data0,
  input  logic [DW-1:0] data1,
  output logic [1:0]    grant,
  input  logic          dac_cs,
  output logic [DW-1:0] dac_data,
  output logic          dac_load,
  output logic          busy,
  output logic [7:0]    overrun_cnt,
  output logic          timeout_err
);

  localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t         state, state_nxt;
  logic           tick;
  logic           cs_meta, cs_s;
  logic           rr_last;
  logic           win;
  logic [WCW-1:0] wait_cnt, wait_nxt;
  logic           set_err;

  rate_tick #(.DIV(DIV)) u_rate_tick (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .tick   (tick)
  );

  // dac_cs crosses from the SPI shifter; idles high
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      cs_meta <= 1'b1;
      cs_s    <= 1'b1;
    end else begin
      cs_meta <= dac_cs;
      cs_s    <= cs_meta;
    end
  end

  // Arbitration is combinational so grant coincides with the capture edge
  always_comb begin
    grant = 2'b00;
    win   = 1'b0;
    if (state == IDLE && tick) begin
      case (req)
        2'b01: begin grant = 2'b01; win = 1'b0; end
        2'b10: begin grant = 2'b10; win = 1'b1; end
        2'b11: begin
          win   = ~rr_last;
          grant = rr_last ? 2'b01 : 2'b10;
        end
        default: begin grant = 2'b00; win = 1'b0; end
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    set_err   = 1'b0;
    case (state)
      IDLE: begin
        if (grant != 2'b00)
          state_nxt = LOAD;
      end
      LOAD: begin
        wait_nxt  = '0;
        state_nxt = WAIT_FALL;
      end
      WAIT_FALL: begin
        if (!cs_s) begin
          wait_nxt  = '0;
          state_nxt = WAIT_RISE;
        end else if (wait_cnt == WAIT_LAST) begin
          set_err   = 1'b1;
          state_nxt = IDLE;
        end else begin
          wait_nxt = wait_cnt + WCW'(1);
        end
      end
      WAIT_RISE: begin
        if (cs_s) begin
          state_nxt = IDLE;
        end else if (wait_cnt == WAIT_LAST) begin
          set_err   = 1'b1;
          state_nxt = IDLE;
        end else begin
          wait_nxt = wait_cnt + WCW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  // Winner capture and round-robin history; rr_last=1 favours source 0 first
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      dac_data <= '0;
      rr_last  <= 1'b1;
    end else if (grant != 2'b00) begin
      dac_data <= win ? data1 : data0;
      rr_last  <= win;
    end
  end

  // A tick outside IDLE drops that slot; it is only counted
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_cnt <= 8'd0;
      timeout_err <= 1'b0;
    end else begin
      if (tick && state != IDLE)
        overrun_cnt <= sat_inc8(overrun_cnt);
      if (set_err)
        timeout_err <= 1'b1;
    end
  end

  assign dac_load = (state == LOAD);
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Scoreboard bench for dac_sample_scheduler: a DIV=100 instance under
// directed slots plus a DIV=20 instance for the overrun pattern.
module tb_dac_sample_scheduler;

  typedef struct {
    logic [1:0] g;
    logic [9:0] d;
    int         c;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  int         cyc;
  int         n_cmp = 0;
  int         n_bad = 0;

  logic [1:0] req_a = 2'b00;
  logic [9:0] data0_a = 10'h3C3, data1_a = 10'h0F0;
  logic [1:0] grant_a;
  logic       cs_a = 1'b1;
  logic       cs_en = 1'b1;
  logic [9:0] dac_data_a;
  logic       dac_load_a, busy_a, timeout_a;
  logic [7:0] overrun_a;

  logic [1:0] req_b = 2'b01;
  logic [9:0] data0_b = 10'h2AA, data1_b = 10'h111;
  logic [1:0] grant_b;
  logic       cs_b = 1'b1;
  logic [9:0] dac_data_b;
  logic       dac_load_b, busy_b, timeout_b;
  logic [7:0] overrun_b;
  int         loads_b = 0;
  logic       busy_prev_b = 1'b0;

  exp_t       q[$];
  exp_t       e_mon;
  logic [1:0] gprev = 2'b00;

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  dac_sample_scheduler #(.DW(10), .DIV(100), .TIMEOUT(255)) u_dut (
    .sysclk      (clk),
    .rst_n       (rst_n),
    .req         (req_a),
    .data0       (data0_a),
    .data1       (data1_a),
    .grant       (grant_a),
    .dac_cs      (cs_a),
    .dac_data    (dac_data_a),
    .dac_load    (dac_load_a),
    .busy        (busy_a),
    .overrun_cnt (overrun_a),
    .timeout_err (timeout_a)
  );

  dac_sample_scheduler #(.DW(10), .DIV(20), .TIMEOUT(255)) u_fast (
    .sysclk      (clk),
    .rst_n       (rst_n),
    .req         (req_b),
    .data0       (data0_b),
    .data1       (data1_b),
    .grant       (grant_b),
    .dac_cs      (cs_b),
    .dac_data    (dac_data_b),
    .dac_load    (dac_load_b),
    .busy        (busy_b),
    .overrun_cnt (overrun_b),
    .timeout_err (timeout_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic push(input logic [1:0] g, input logic [9:0] d, input int c);
    exp_t e;
    e.g = g; e.d = d; e.c = c;
    q.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_grant",    grant_a,    0);
    check("rst_load",     dac_load_a, 0);
    check("rst_data",     dac_data_a, 0);
    check("rst_busy",     busy_a,     0);
    check("rst_overrun",  overrun_a,  0);
    check("rst_timeout",  timeout_a,  0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // spi2dac stand-in for the DIV=100 instance
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && dac_load_a && cs_en) begin
        repeat (20) @(negedge clk);
        cs_a = 1'b0;
        repeat (34) @(negedge clk);
        cs_a = 1'b1;
      end
    end
  end

  // spi2dac stand-in for the DIV=20 instance: frame starts right after load
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && dac_load_b) begin
        cs_b = 1'b0;
        repeat (34) @(negedge clk);
        cs_b = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && dac_load_b) begin
        loads_b++;
        check("fast_load_from_idle", busy_prev_b, 0);
      end
      busy_prev_b = busy_b;
    end
  end

  // Scoreboard monitor for the DIV=100 instance
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        gprev = 2'b00;
      end else begin
        if (grant_a != 2'b00 && q.size() == 0)
          check("unexpected_grant", grant_a, 0);
        if (dac_load_a) begin
          if (q.size() == 0) begin
            check("unexpected_load", dac_load_a, 0);
          end else begin
            e_mon = q.pop_front();
            check("load_grant", gprev, e_mon.g);
            check("load_data", dac_data_a, e_mon.d);
            check("load_cycle", cyc, e_mon.c);
          end
        end
        gprev = grant_a;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    check("init_grant",   grant_a,    0);
    check("init_load",    dac_load_a, 0);
    check("init_data",    dac_data_a, 0);
    check("init_busy",    busy_a,     0);
    check("init_overrun", overrun_a,  0);
    check("init_timeout", timeout_a,  0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fast instance overruns every other slot; slow instance sees no requests
    wait_cyc(205);
    check("fast_overrun", overrun_b, 5);
    check("fast_loads",   loads_b,   5);
    check("fast_timeout", timeout_b, 0);
    req_b = 2'b00;
    wait_cyc(305);
    check("noreq_data", dac_data_a, 0);
    check("noreq_busy", busy_a,     0);

    do_reset();
    req_a   = 2'b01;
    data0_a = 10'h155;
    push(2'b01, 10'h155, 100);
    wait_cyc(101);
    req_a = 2'b00;
    wait_cyc(150);
    check("frame_busy", busy_a,     1);
    check("frame_data", dac_data_a, 10'h155);
    wait_cyc(190);
    check("post_busy",    busy_a,     0);
    check("post_overrun", overrun_a,  0);
    check("post_data",    dac_data_a, 10'h155);

    // Contention: source 0 won last, so source 1 goes first here
    req_a   = 2'b11;
    data0_a = 10'h001;
    data1_a = 10'h3FF;
    push(2'b10, 10'h3FF, 200);
    push(2'b01, 10'h001, 300);
    push(2'b10, 10'h3FF, 400);
    push(2'b01, 10'h001, 500);
    wait_cyc(540);
    check("pre_rst_busy", busy_a, 1);

    do_reset();
    push(2'b01, 10'h001, 100);
    push(2'b10, 10'h3FF, 200);
    wait_cyc(201);
    req_a = 2'b00;

    // dac_cs never falls: WAIT_FALL must give up after 255 cycles
    wait_cyc(300);
    cs_en   = 1'b0;
    req_a   = 2'b01;
    data0_a = 10'h0AA;
    push(2'b01, 10'h0AA, 400);
    wait_cyc(401);
    req_a = 2'b00;
    wait_cyc(655);
    check("to_busy_last",  busy_a,    1);
    check("to_err_before", timeout_a, 0);
    wait_cyc(656);
    check("to_err_set",   timeout_a, 1);
    check("to_idle",      busy_a,    0);
    check("to_overrun",   overrun_a, 2);
    wait_cyc(660);
    req_a   = 2'b01;
    data0_a = 10'h0CC;
    push(2'b01, 10'h0CC, 700);
    wait_cyc(701);
    req_a = 2'b00;
    wait_cyc(710);
    check("to_sticky", timeout_a, 1);
    check("sb_empty",  q.size(),  0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
